// File: rtl/ctrl_pipe_if.sv
`default_nettype none
//============================================================================
// Module   : ctrl_pipe_if
// Brief    : D-stage instruction/hazard inputs and per-stage control outputs
//            exchanged between the datapath and ctrl_pipe.
// Revision : 1.0 - initial release
//============================================================================
interface ctrl_pipe_if #(
    parameter int ALUCTRL_W = 4
);
    logic [31:0]          InstrD;
    logic                 StallD;
    logic                 FlushE;

    logic                 RegWriteD, RegWriteE, RegWriteM, RegWriteW;
    logic                 MemtoRegD, MemtoRegE, MemtoRegM, MemtoRegW;
    logic                 MemWriteD, MemWriteE, MemWriteM;
    logic [ALUCTRL_W-1:0] ALUCtrlD, ALUCtrlE;
    logic                 ALUSrcD, ALUSrcE;
    logic [1:0]           RegDstD, RegDstE;
    logic                 LinkD, LinkE, LinkM, LinkW;
    logic                 JumpD, JumpRegD, BeqD, BneD, BgtzD;
    logic                 MdStartE, MdBusy, StallMD;
    logic                 ReservedD;

    modport master (
        output InstrD, StallD, FlushE,
        input  RegWriteD, RegWriteE, RegWriteM, RegWriteW,
        input  MemtoRegD, MemtoRegE, MemtoRegM, MemtoRegW,
        input  MemWriteD, MemWriteE, MemWriteM,
        input  ALUCtrlD, ALUCtrlE, ALUSrcD, ALUSrcE, RegDstD, RegDstE,
        input  LinkD, LinkE, LinkM, LinkW,
        input  JumpD, JumpRegD, BeqD, BneD, BgtzD,
        input  MdStartE, MdBusy, StallMD, ReservedD
    );

    modport slave (
        input  InstrD, StallD, FlushE,
        output RegWriteD, RegWriteE, RegWriteM, RegWriteW,
        output MemtoRegD, MemtoRegE, MemtoRegM, MemtoRegW,
        output MemWriteD, MemWriteE, MemWriteM,
        output ALUCtrlD, ALUCtrlE, ALUSrcD, ALUSrcE, RegDstD, RegDstE,
        output LinkD, LinkE, LinkM, LinkW,
        output JumpD, JumpRegD, BeqD, BneD, BgtzD,
        output MdStartE, MdBusy, StallMD, ReservedD
    );
endinterface
`default_nettype wire

// File: rtl/ctrl_pipe.sv
`default_nettype none
//============================================================================
// Module   : ctrl_pipe
// Brief    : MIPS D-stage decoder with pipelined E/M/W control registers and
//            a mult/div busy sequencer (present only when CTRL_MD_EN defined).
// Revision : 1.0 - initial release
//============================================================================
module ctrl_pipe #(
    parameter int ALUCTRL_W   = 4,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    ctrl_pipe_if.slave  bus
);

    generate
        if (ALUCTRL_W < 3) begin : g_badAluCtrlW
            $error("ctrl_pipe: ALUCTRL_W must be at least 3");
        end
        if (MULT_CYCLES < 1 || MULT_CYCLES > 15) begin : g_badMultCycles
            $error("ctrl_pipe: MULT_CYCLES must be in 1..15");
        end
        if (DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_badDivCycles
            $error("ctrl_pipe: DIV_CYCLES must be in 1..15");
        end
    endgenerate

    localparam logic [5:0] c_OP_SPECIAL = 6'h00;
    localparam logic [5:0] c_OP_J       = 6'h02;
    localparam logic [5:0] c_OP_JAL     = 6'h03;
    localparam logic [5:0] c_OP_BEQ     = 6'h04;
    localparam logic [5:0] c_OP_BNE     = 6'h05;
    localparam logic [5:0] c_OP_BGTZ    = 6'h07;
    localparam logic [5:0] c_OP_ADDI    = 6'h08;
    localparam logic [5:0] c_OP_ADDIU   = 6'h09;
    localparam logic [5:0] c_OP_ORI     = 6'h0D;
    localparam logic [5:0] c_OP_LUI     = 6'h0F;
    localparam logic [5:0] c_OP_LW      = 6'h23;
    localparam logic [5:0] c_OP_SW      = 6'h2B;

    localparam logic [5:0] c_FN_JR      = 6'h08;
    localparam logic [5:0] c_FN_ADD     = 6'h20;
    localparam logic [5:0] c_FN_ADDU    = 6'h21;
    localparam logic [5:0] c_FN_SUB     = 6'h22;
    localparam logic [5:0] c_FN_SUBU    = 6'h23;
    localparam logic [5:0] c_FN_AND     = 6'h24;
    localparam logic [5:0] c_FN_OR      = 6'h25;
    localparam logic [5:0] c_FN_SLT     = 6'h2A;
`ifdef CTRL_MD_EN
    localparam logic [5:0] c_FN_MFHI    = 6'h10;
    localparam logic [5:0] c_FN_MTHI    = 6'h11;
    localparam logic [5:0] c_FN_MFLO    = 6'h12;
    localparam logic [5:0] c_FN_MTLO    = 6'h13;
    localparam logic [5:0] c_FN_MULT    = 6'h18;
    localparam logic [5:0] c_FN_MULTU   = 6'h19;
    localparam logic [5:0] c_FN_DIV     = 6'h1A;
    localparam logic [5:0] c_FN_DIVU    = 6'h1B;
`endif

    localparam logic [ALUCTRL_W-1:0] c_ALU_ADD = ALUCTRL_W'(0);
    localparam logic [ALUCTRL_W-1:0] c_ALU_SUB = ALUCTRL_W'(1);
    localparam logic [ALUCTRL_W-1:0] c_ALU_OR  = ALUCTRL_W'(2);
    localparam logic [ALUCTRL_W-1:0] c_ALU_LUI = ALUCTRL_W'(3);
    localparam logic [ALUCTRL_W-1:0] c_ALU_AND = ALUCTRL_W'(4);
    localparam logic [ALUCTRL_W-1:0] c_ALU_SLT = ALUCTRL_W'(5);

    // Fields that travel into the E stage register.
    typedef struct packed {
        logic                 regWrite;
        logic                 memtoReg;
        logic                 memWrite;
        logic [ALUCTRL_W-1:0] aluCtrl;
        logic                 aluSrc;
        logic [1:0]           regDst;
        logic                 link;
    } ctrlE_t;

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic [4:0] w_rt;
    logic       w_unused;
    ctrlE_t     w_ctrlD;
    logic       w_jump, w_jumpReg, w_beq, w_bne, w_bgtz, w_reserved;
`ifdef CTRL_MD_EN
    logic       w_mdOpD, w_mdDivD, w_mdGroupD;
`endif

    assign w_op     = bus.InstrD[31:26];
    assign w_funct  = bus.InstrD[5:0];
    assign w_rt     = bus.InstrD[20:16];
    assign w_unused = ^bus.InstrD;

    always_comb begin
        w_ctrlD    = '0;
        w_jump     = 1'b0;
        w_jumpReg  = 1'b0;
        w_beq      = 1'b0;
        w_bne      = 1'b0;
        w_bgtz     = 1'b0;
        w_reserved = 1'b0;
`ifdef CTRL_MD_EN
        w_mdOpD    = 1'b0;
        w_mdDivD   = 1'b0;
        w_mdGroupD = 1'b0;
`endif
        case (w_op)
            c_OP_SPECIAL: begin
                case (w_funct)
                    c_FN_ADD, c_FN_ADDU: begin
                        w_ctrlD.regWrite = 1'b1;
                        w_ctrlD.regDst   = 2'd1;
                        w_ctrlD.aluCtrl  = c_ALU_ADD;
                    end
                    c_FN_SUB, c_FN_SUBU: begin
                        w_ctrlD.regWrite = 1'b1;
                        w_ctrlD.regDst   = 2'd1;
                        w_ctrlD.aluCtrl  = c_ALU_SUB;
                    end
                    c_FN_AND: begin
                        w_ctrlD.regWrite = 1'b1;
                        w_ctrlD.regDst   = 2'd1;
                        w_ctrlD.aluCtrl  = c_ALU_AND;
                    end
                    c_FN_OR: begin
                        w_ctrlD.regWrite = 1'b1;
                        w_ctrlD.regDst   = 2'd1;
                        w_ctrlD.aluCtrl  = c_ALU_OR;
                    end
                    c_FN_SLT: begin
                        w_ctrlD.regWrite = 1'b1;
                        w_ctrlD.regDst   = 2'd1;
                        w_ctrlD.aluCtrl  = c_ALU_SLT;
                    end
                    c_FN_JR: w_jumpReg = 1'b1;
`ifdef CTRL_MD_EN
                    c_FN_MULT, c_FN_MULTU: begin
                        w_mdOpD    = 1'b1;
                        w_mdGroupD = 1'b1;
                    end
                    c_FN_DIV, c_FN_DIVU: begin
                        w_mdOpD    = 1'b1;
                        w_mdDivD   = 1'b1;
                        w_mdGroupD = 1'b1;
                    end
                    c_FN_MFHI, c_FN_MFLO: begin
                        w_ctrlD.regWrite = 1'b1;
                        w_ctrlD.regDst   = 2'd1;
                        w_mdGroupD       = 1'b1;
                    end
                    c_FN_MTHI, c_FN_MTLO: w_mdGroupD = 1'b1;
`endif
                    default: w_reserved = 1'b1;
                endcase
            end
            c_OP_ORI: begin
                w_ctrlD.regWrite = 1'b1;
                w_ctrlD.aluSrc   = 1'b1;
                w_ctrlD.aluCtrl  = c_ALU_OR;
            end
            c_OP_LUI: begin
                w_ctrlD.regWrite = 1'b1;
                w_ctrlD.aluSrc   = 1'b1;
                w_ctrlD.aluCtrl  = c_ALU_LUI;
            end
            c_OP_ADDI, c_OP_ADDIU: begin
                w_ctrlD.regWrite = 1'b1;
                w_ctrlD.aluSrc   = 1'b1;
            end
            c_OP_LW: begin
                w_ctrlD.regWrite = 1'b1;
                w_ctrlD.memtoReg = 1'b1;
                w_ctrlD.aluSrc   = 1'b1;
            end
            c_OP_SW: begin
                w_ctrlD.memWrite = 1'b1;
                w_ctrlD.aluSrc   = 1'b1;
            end
            c_OP_BEQ: begin
                w_beq           = 1'b1;
                w_ctrlD.aluCtrl = c_ALU_SUB;
            end
            c_OP_BNE: begin
                w_bne           = 1'b1;
                w_ctrlD.aluCtrl = c_ALU_SUB;
            end
            // bgtz with a non-zero rt field is not a legal encoding.
            c_OP_BGTZ: begin
                if (w_rt == 5'd0) w_bgtz     = 1'b1;
                else              w_reserved = 1'b1;
            end
            c_OP_J:  w_jump = 1'b1;
            c_OP_JAL: begin
                w_jump           = 1'b1;
                w_ctrlD.regWrite = 1'b1;
                w_ctrlD.regDst   = 2'd2;
                w_ctrlD.link     = 1'b1;
            end
            default: w_reserved = 1'b1;
        endcase
    end

    ctrlE_t r_ctrlE;
    logic   r_regWriteM, r_memtoRegM, r_memWriteM, r_linkM;
    logic   r_regWriteW, r_memtoRegW, r_linkW;
`ifdef CTRL_MD_EN
    logic   r_mdOpE, r_mdDivE;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrlE  <= '0;
`ifdef CTRL_MD_EN
            r_mdOpE  <= 1'b0;
            r_mdDivE <= 1'b0;
`endif
        end else if (bus.StallD | bus.FlushE) begin
            r_ctrlE  <= '0;
`ifdef CTRL_MD_EN
            r_mdOpE  <= 1'b0;
            r_mdDivE <= 1'b0;
`endif
        end else begin
            r_ctrlE  <= w_ctrlD;
`ifdef CTRL_MD_EN
            r_mdOpE  <= w_mdOpD;
            r_mdDivE <= w_mdDivD;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regWriteM <= 1'b0;
            r_memtoRegM <= 1'b0;
            r_memWriteM <= 1'b0;
            r_linkM     <= 1'b0;
            r_regWriteW <= 1'b0;
            r_memtoRegW <= 1'b0;
            r_linkW     <= 1'b0;
        end else begin
            r_regWriteM <= r_ctrlE.regWrite;
            r_memtoRegM <= r_ctrlE.memtoReg;
            r_memWriteM <= r_ctrlE.memWrite;
            r_linkM     <= r_ctrlE.link;
            r_regWriteW <= r_regWriteM;
            r_memtoRegW <= r_memtoRegM;
            r_linkW     <= r_linkM;
        end
    end

`ifdef CTRL_MD_EN
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } mdState_t;

    localparam logic [3:0] c_MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] c_DIV_CNT  = 4'(DIV_CYCLES);

    mdState_t   r_mdState, w_mdStateNext;
    logic [3:0] r_mdCount, w_mdCountNext;
    logic       w_mdStart;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mdState <= S_IDLE;
            r_mdCount <= 4'd0;
        end else begin
            r_mdState <= w_mdStateNext;
            r_mdCount <= w_mdCountNext;
        end
    end

    // An op in E is only accepted from IDLE; the stall request guarantees a
    // bubble follows it, so it is never seen twice.
    always_comb begin
        w_mdStateNext = r_mdState;
        w_mdCountNext = r_mdCount;
        w_mdStart     = 1'b0;
        case (r_mdState)
            S_IDLE: begin
                if (r_mdOpE) begin
                    w_mdStart     = 1'b1;
                    w_mdStateNext = S_BUSY;
                    w_mdCountNext = r_mdDivE ? c_DIV_CNT : c_MULT_CNT;
                end
            end
            S_BUSY: begin
                w_mdCountNext = r_mdCount - 4'd1;
                if (r_mdCount == 4'd1) w_mdStateNext = S_IDLE;
            end
            default: w_mdStateNext = S_IDLE;
        endcase
    end

    assign bus.MdStartE = w_mdStart;
    assign bus.MdBusy   = (r_mdState == S_BUSY);
    assign bus.StallMD  = w_mdGroupD & ((r_mdState == S_BUSY) | w_mdStart);
`else
    assign bus.MdStartE = 1'b0;
    assign bus.MdBusy   = 1'b0;
    assign bus.StallMD  = 1'b0;
`endif

    assign bus.RegWriteD = w_ctrlD.regWrite;
    assign bus.MemtoRegD = w_ctrlD.memtoReg;
    assign bus.MemWriteD = w_ctrlD.memWrite;
    assign bus.ALUCtrlD  = w_ctrlD.aluCtrl;
    assign bus.ALUSrcD   = w_ctrlD.aluSrc;
    assign bus.RegDstD   = w_ctrlD.regDst;
    assign bus.LinkD     = w_ctrlD.link;
    assign bus.JumpD     = w_jump;
    assign bus.JumpRegD  = w_jumpReg;
    assign bus.BeqD      = w_beq;
    assign bus.BneD      = w_bne;
    assign bus.BgtzD     = w_bgtz;
    assign bus.ReservedD = w_reserved;

    assign bus.RegWriteE = r_ctrlE.regWrite;
    assign bus.MemtoRegE = r_ctrlE.memtoReg;
    assign bus.MemWriteE = r_ctrlE.memWrite;
    assign bus.ALUCtrlE  = r_ctrlE.aluCtrl;
    assign bus.ALUSrcE   = r_ctrlE.aluSrc;
    assign bus.RegDstE   = r_ctrlE.regDst;
    assign bus.LinkE     = r_ctrlE.link;

    assign bus.RegWriteM = r_regWriteM;
    assign bus.MemtoRegM = r_memtoRegM;
    assign bus.MemWriteM = r_memWriteM;
    assign bus.LinkM     = r_linkM;
    assign bus.RegWriteW = r_regWriteW;
    assign bus.MemtoRegW = r_memtoRegW;
    assign bus.LinkW     = r_linkW;

endmodule
`default_nettype wire

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
Next-generation control unit for the 5-stage MIPS core. It decodes the D-stage instruction into a control bundle and pipelines that bundle through the E, M and W stage registers, with stall and flush. It also owns a multi-cycle multiply/divide busy sequencer that generates its own stall request. It replaces the purely combinational D-stage decoder, so the datapath stops carrying per-stage control registers.

Parameters:
ALUCTRL_W, 4, width of the ALU control field; must be at least 3.
MULT_CYCLES, 5, E-stage busy cycles for mult/multu; valid range 1..15.
DIV_CYCLES, 10, E-stage busy cycles for div/divu; valid range 1..15.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
InstrD  in  32  instruction in the D stage
StallD  in  1  hazard-unit stall; E receives a bubble
FlushE  in  1  flush; E receives a bubble
RegWriteD/E/M/W  out  1 each  register-file write enable per stage
MemtoRegD/E/M/W  out  1 each  load-result select per stage
MemWriteD/E/M  out  1 each  data-memory write per stage
ALUCtrlD/E  out  ALUCTRL_W each  0 add, 1 sub, 2 or, 3 lui, 4 and, 5 slt
ALUSrcD/E  out  1 each  immediate operand select
RegDstD/E  out  2 each  0 rt, 1 rd, 2 $31
LinkD/E/M/W  out  1 each  write PC+8 (jal)
JumpD, JumpRegD, BeqD, BneD, BgtzD  out  1 each  D-stage branch/jump decode
MdStartE  out  1  mult/div accepted this cycle
MdBusy  out  1  mult/div sequencer busy
StallMD  out  1  stall request to the hazard unit
ReservedD  out  1  unrecognised or illegal encoding in D

Behaviour:
- Decoded set: addu, add, subu, sub, and, or, slt, jr, mult, multu, div, divu, mfhi, mflo, mthi, mtlo (SPECIAL funct); ori, lui, addi, addiu, lw, sw, beq, bne, bgtz, j, jal.
- bgtz is legal only with rt = 0; otherwise ReservedD = 1.
- Reserved instructions decode to all-zero control, i.e. a NOP; ReservedD = 1 is combinational.
- D outputs are combinational from InstrD, with no latency.
- E register: loads a bubble (all fields 0) when rst_n = 0, or at a rising edge with FlushE | StallD; otherwise it loads the D bundle. FlushE and StallD together: bubble.
- M and W registers: always advance, with E->M and M->W. Total latency D->W is 3 edges.
- Reset: every registered output is 0; counter = 0, MdBusy = 0. Reset is asynchronous and may assert mid-sequence; the sequencer aborts immediately.
- Sequencer states: IDLE and BUSY, with a 4-bit down-counter.
  - IDLE: if the E stage holds mult/multu (or div/divu), MdStartE = 1 (combinational). At the next edge the counter loads MULT_CYCLES (or DIV_CYCLES) and the state moves to BUSY.
  - BUSY: the counter decrements each edge. At 1 -> 0 the state returns to IDLE.
  - MdBusy = (state == BUSY).
- StallMD = (D holds mult/div/mfhi/mflo/mthi/mtlo) & (MdBusy | MdStartE).
- A mult/div in E is never restarted: it is accepted once, because a bubble follows via StallD.
- A FlushE in the same cycle as MdStartE does not cancel the started operation.

Optional Feature:
CTRL_MD_EN.
- Defined: mult/div group and sequencer as above.
- Undefined: mult, multu, div, divu, mfhi, mflo, mthi and mtlo decode as reserved (ReservedD = 1, NOP). MdStartE, MdBusy and StallMD are tied to 0, and no sequencer logic is synthesised.

Test Plan:
- Reset: rst_n low mid-run with InstrD = 0x00221821 (addu) -> all registered outputs 0 immediately, without waiting for a clock edge.
- InstrD = 0x00221821 (addu) -> RegDstD = 1, ALUCtrlD = 0, RegWriteD = 1; then RegWriteE, RegWriteM, RegWriteW go high 1, 2 and 3 edges later.
- InstrD = 0x8FA80004 (lw) with StallD = 1 for one edge -> E is a bubble (RegWriteE = 0, MemtoRegE = 0); with StallD released, MemtoRegE = 1 after the next edge.
- InstrD = 0x00220018 (mult), then 0x00001812 (mflo) with CTRL_MD_EN defined and MULT_CYCLES = 5:
  - MdStartE = 1 for 1 cycle.
  - MdBusy = 1 for exactly 5 cycles.
  - StallMD = 1 throughout, then falls to 0.
- InstrD = 0x1C210003 (bgtz, rt = 1) -> ReservedD = 1, BgtzD = 0. InstrD = 0x1C200003 -> BgtzD = 1, ReservedD = 0.
- CTRL_MD_EN undefined, InstrD = 0x0022001A (div) -> ReservedD = 1, StallMD = 0, MdBusy remains 0.
